// File: rtl/prog_mem_seq.sv
// Program memory with clear/load/fetch sequencer: DEPTH words of INSTR_W bits, 1-cycle fetch.
// Optional build macro PROG_MEM_PARITY_EN adds a stored even-parity bit, fetch_perr and inj_perr.
module prog_mem_seq #(
  parameter int                 INSTR_W   = 16,
  parameter int                 DEPTH     = 32,
  parameter int                 ADDR_W    = $clog2(DEPTH),
  parameter logic [INSTR_W-1:0] FILL_WORD = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_rdy,
  output logic               fetch_vld,
  output logic [INSTR_W-1:0] fetch_data,
  output logic               fetch_oor,
  input  logic               load_start,
  input  logic               load_vld,
  input  logic               load_last,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_rdy,
  output logic               load_done,
  output logic               busy
`ifdef PROG_MEM_PARITY_EN
  ,
  output logic               fetch_perr,
  input  logic               inj_perr
`endif
);

`ifdef PROG_MEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int                MEM_W     = INSTR_W + PAR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       DEPTH_U   = DEPTH;

  typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    ptr_q, ptr_d;
  logic                 fetch_vld_q, fetch_vld_d;
  logic                 fetch_oor_q, fetch_oor_d;
  logic [INSTR_W-1:0]   fetch_data_q, fetch_data_d;
  logic                 load_done_q, load_done_d;

  logic [MEM_W-1:0]     mem [DEPTH];
  logic                 mem_we;
  logic                 wr_from_load;
  logic [INSTR_W-1:0]   wr_data;
  logic [MEM_W-1:0]     wr_word;
  logic [ADDR_W-1:0]    rd_addr;
  logic [MEM_W-1:0]     rd_word;
  logic                 fetch_acc;
  logic                 fetch_in_range;

  // Sequencer: decides the write port, pointer and whether a fetch is accepted this cycle.
  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    mem_we       = 1'b0;
    wr_from_load = 1'b0;
    wr_data      = FILL_WORD;
    fetch_acc    = 1'b0;
    load_done_d  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST_ADDR) state_d = IDLE;
      end
      IDLE: begin
        if (load_start) begin
          ptr_d   = '0;
          state_d = LOAD;
        end else begin
          fetch_acc = fetch_req;
        end
      end
      LOAD: begin
        if (load_vld) begin
          mem_we       = 1'b1;
          wr_from_load = 1'b1;
          wr_data      = load_data;
          ptr_d        = ptr_q + ADDR_W'(1);
          if (load_last || ptr_q == LAST_ADDR) begin
            state_d     = IDLE;
            load_done_d = 1'b1;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Fetch path: out-of-range addresses read a safe location and return FILL_WORD instead.
  always_comb begin
    fetch_in_range = 32'(fetch_addr) < DEPTH_U;
    rd_addr        = fetch_in_range ? fetch_addr : '0;
    rd_word        = mem[rd_addr];
    fetch_vld_d    = fetch_acc;
    fetch_oor_d    = fetch_acc && !fetch_in_range;
    fetch_data_d   = fetch_data_q;
    if (fetch_acc) fetch_data_d = fetch_in_range ? rd_word[INSTR_W-1:0] : FILL_WORD;
  end

`ifdef PROG_MEM_PARITY_EN
  logic fetch_perr_q, fetch_perr_d;

  // Stored bit makes the whole word XOR to 0; a nonzero XOR on read flags corruption.
  always_comb begin
    wr_word      = {(^wr_data) ^ (wr_from_load & inj_perr), wr_data};
    fetch_perr_d = fetch_acc && fetch_in_range && (^rd_word);
  end

  always_ff @(posedge clk) begin
    if (rst) fetch_perr_q <= 1'b0;
    else     fetch_perr_q <= fetch_perr_d;
  end

  assign fetch_perr = fetch_perr_q;
`else
  always_comb begin
    wr_word = wr_data;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      ptr_q        <= '0;
      fetch_vld_q  <= 1'b0;
      fetch_oor_q  <= 1'b0;
      fetch_data_q <= FILL_WORD;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      fetch_vld_q  <= fetch_vld_d;
      fetch_oor_q  <= fetch_oor_d;
      fetch_data_q <= fetch_data_d;
      load_done_q  <= load_done_d;
    end
  end

  // NOTE: the array has no reset; the CLEAR sweep initialises it, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[ptr_q] <= wr_word;
  end

  assign fetch_rdy  = (state_q == IDLE);
  assign load_rdy   = (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign fetch_vld  = fetch_vld_q;
  assign fetch_oor  = fetch_oor_q;
  assign fetch_data = fetch_data_q;
  assign load_done  = load_done_q;

endmodule

// File: tb/tb_prog_mem_seq.sv
// Self-checking bench for prog_mem_seq: a DEPTH=32 and a DEPTH=20 instance share one stimulus
// stream and are checked against a word-array model of the program store.
module tb_prog_mem_seq;
  localparam int             W    = 16;
  localparam int             NI   = 2;
  localparam logic [W-1:0]   FILL = 16'hC3A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fetch_req = 1'b0, load_start = 1'b0, load_vld = 1'b0, load_last = 1'b0, inj_perr = 1'b0;
  logic [4:0]   fetch_addr = '0;
  logic [W-1:0] load_data = '0;

  logic [NI-1:0] fetch_rdy, fetch_vld, fetch_oor, load_rdy, load_done, busy, fetch_perr;
  logic [W-1:0]  fetch_data [NI];

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mmem    [NI][32];
  bit           mbad    [NI][32];
  bit           in_load [NI];
  int           cnt     [NI];

  logic [4:0]   fq[$];
  logic [W-1:0] pq[$];

  always #5 clk = ~clk;

  prog_mem_seq #(.INSTR_W(W), .DEPTH(32), .FILL_WORD(FILL)) u_dut32 (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_rdy(fetch_rdy[0]), .fetch_vld(fetch_vld[0]), .fetch_data(fetch_data[0]),
    .fetch_oor(fetch_oor[0]), .load_start(load_start), .load_vld(load_vld),
    .load_last(load_last), .load_data(load_data), .load_rdy(load_rdy[0]),
    .load_done(load_done[0]), .busy(busy[0])
`ifdef PROG_MEM_PARITY_EN
    , .fetch_perr(fetch_perr[0]), .inj_perr(inj_perr)
`endif
  );

  prog_mem_seq #(.INSTR_W(W), .DEPTH(20), .FILL_WORD(FILL)) u_dut20 (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_rdy(fetch_rdy[1]), .fetch_vld(fetch_vld[1]), .fetch_data(fetch_data[1]),
    .fetch_oor(fetch_oor[1]), .load_start(load_start), .load_vld(load_vld),
    .load_last(load_last), .load_data(load_data), .load_rdy(load_rdy[1]),
    .load_done(load_done[1]), .busy(busy[1])
`ifdef PROG_MEM_PARITY_EN
    , .fetch_perr(fetch_perr[1]), .inj_perr(inj_perr)
`endif
  );

`ifndef PROG_MEM_PARITY_EN
  assign fetch_perr = '0;
`endif

  function automatic int dep(input int i);
    return (i == 0) ? 32 : 20;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      in_load[i] = 1'b0;
      cnt[i]     = 0;
      for (int a = 0; a < 32; a++) begin
        mmem[i][a] = FILL;
        mbad[i][a] = 1'b0;
      end
    end
  endtask

  // Two reset cycles, then the clear sweep; a fetch is held requested the whole time.
  task automatic do_reset();
    logic [4:0] a;
    a = 5'($urandom_range(0, 31));
    rst = 1'b1; load_start = 1'b0; load_vld = 1'b0; load_last = 1'b0; inj_perr = 1'b0;
    fetch_req = 1'b1; fetch_addr = a;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_vld[%0d]", i), 32'(fetch_vld[i]), 32'd0);
      check($sformatf("rst_oor[%0d]", i), 32'(fetch_oor[i]), 32'd0);
      check($sformatf("rst_data[%0d]", i), 32'(fetch_data[i]), 32'(FILL));
      check($sformatf("rst_lrdy[%0d]", i), 32'(load_rdy[i]), 32'd0);
      check($sformatf("rst_ldone[%0d]", i), 32'(load_done[i]), 32'd0);
      check($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int c = 0; c <= 35; c++) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("clr_busy[%0d]c%0d", i, c), 32'(busy[i]), 32'(c < dep(i)));
        check($sformatf("clr_frdy[%0d]c%0d", i, c), 32'(fetch_rdy[i]), 32'(c >= dep(i)));
        check($sformatf("clr_vld[%0d]c%0d", i, c), 32'(fetch_vld[i]), 32'(c > dep(i)));
        check($sformatf("clr_ldone[%0d]c%0d", i, c), 32'(load_done[i]), 32'd0);
        if (c > dep(i)) begin
          check($sformatf("clr_data[%0d]", i), 32'(fetch_data[i]), 32'(FILL));
          check($sformatf("clr_oor[%0d]", i), 32'(fetch_oor[i]), 32'(int'(a) >= dep(i)));
        end
      end
      @(negedge clk);
    end
    fetch_req = 1'b0;
    @(negedge clk);
  endtask

  // Back-to-back fetches of fq; each result is checked one cycle after its request.
  task automatic fetch_seq();
    int  a;
    bit  inr;
    foreach (fq[k]) begin
      fetch_req  = 1'b1;
      fetch_addr = fq[k];
      a = int'(fq[k]);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        inr = a < dep(i);
        check($sformatf("f_vld[%0d]a%0d", i, a), 32'(fetch_vld[i]), 32'd1);
        check($sformatf("f_data[%0d]a%0d", i, a), 32'(fetch_data[i]),
              32'(inr ? mmem[i][a] : FILL));
        check($sformatf("f_oor[%0d]a%0d", i, a), 32'(fetch_oor[i]), 32'(!inr));
`ifdef PROG_MEM_PARITY_EN
        check($sformatf("f_perr[%0d]a%0d", i, a), 32'(fetch_perr[i]), 32'(inr && mbad[i][a]));
`endif
      end
    end
    fetch_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) check($sformatf("f_idle_vld[%0d]", i), 32'(fetch_vld[i]), 32'd0);
  endtask

  // Streams pq into both instances; each stops at its own last word or its own DEPTH.
  task automatic run_load(input int last_idx, input bit gaps, input bit fetch_hold,
                          input int rst_after, input int inj_idx);
    int w;
    bit v, ex, was;
    bit done_exp;
    load_start = 1'b1;
    fetch_req  = fetch_hold;
    fetch_addr = 5'($urandom_range(0, 19));
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("ls_vld[%0d]", i), 32'(fetch_vld[i]), 32'd0);
      check($sformatf("ls_lrdy[%0d]", i), 32'(load_rdy[i]), 32'd1);
      check($sformatf("ls_busy[%0d]", i), 32'(busy[i]), 32'd1);
      in_load[i] = 1'b1;
      cnt[i]     = 0;
    end
    w = 0;
    for (int cyc = 0; cyc < 400 && w < pq.size(); cyc++) begin
      if (w == rst_after) break;
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      load_vld = v; load_data = pq[w]; load_last = (w == last_idx); inj_perr = (w == inj_idx);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        was      = in_load[i];
        done_exp = 1'b0;
        if (in_load[i] && v) begin
          mmem[i][cnt[i]] = pq[w];
          mbad[i][cnt[i]] = (w == inj_idx);
          ex = (w == last_idx) || (cnt[i] == dep(i) - 1);
          cnt[i]++;
          if (ex) begin
            in_load[i] = 1'b0;
            done_exp   = 1'b1;
          end
        end
        check($sformatf("ld_lrdy[%0d]w%0d", i, w), 32'(load_rdy[i]), 32'(in_load[i]));
        check($sformatf("ld_busy[%0d]w%0d", i, w), 32'(busy[i]), 32'(in_load[i]));
        check($sformatf("ld_done[%0d]w%0d", i, w), 32'(load_done[i]), 32'(done_exp));
        check($sformatf("ld_fvld[%0d]w%0d", i, w), 32'(fetch_vld[i]), 32'(fetch_hold && !was));
      end
      if (v) w++;
    end
    load_vld = 1'b0; load_last = 1'b0; inj_perr = 1'b0;
    if (rst_after >= 0) begin
      do_reset();
    end else begin
      @(negedge clk);
      fetch_req = 1'b0;
      for (int i = 0; i < NI; i++) begin
        check($sformatf("le_lrdy[%0d]", i), 32'(load_rdy[i]), 32'd0);
        check($sformatf("le_done[%0d]", i), 32'(load_done[i]), 32'd0);
        check($sformatf("le_fvld[%0d]", i), 32'(fetch_vld[i]), 32'(fetch_hold));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    // Power-up reset and clear sweep, then every address of both instances reads FILL.
    do_reset();
    fq.delete();
    for (int a = 0; a < 32; a++) fq.push_back(5'(a));
    fetch_seq();

    // Three-word program terminated by load_last.
    pq = '{16'h0011, 16'h0022, 16'h0033};
    run_load(2, 1'b0, 1'b0, -1, -1);
    fq = '{5'd0, 5'd1, 5'd2, 5'd3};
    fetch_seq();

    // Forty words with no load_last: each instance stops at its own DEPTH.
    pq.delete();
    for (int k = 0; k < 40; k++) pq.push_back(16'(16'h1000 + k * 16'h0101));
    run_load(-1, 1'b0, 1'b0, -1, -1);
    fq = '{5'd31, 5'd19, 5'd20, 5'd0};
    fetch_seq();

    // Out-of-range fetch, then load_start colliding with a fetch request.
    fq = '{5'd25};
    fetch_seq();
    pq = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
    run_load(3, 1'b0, 1'b1, -1, -1);
    fq = '{5'd0, 5'd3, 5'd4};
    fetch_seq();

    // Reset after 5 of 10 words: sweep reruns and no load_done appears.
    pq.delete();
    for (int k = 0; k < 10; k++) pq.push_back(16'(16'hB000 + k));
    run_load(-1, 1'b0, 1'b0, 5, -1);
    fq = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4};
    fetch_seq();

    // Parity injection on word 0, word 1 clean.
    pq = '{16'h1234, 16'h5678};
    run_load(1, 1'b0, 1'b0, -1, 0);
    fq = '{5'd0, 5'd1};
    fetch_seq();

    // Random programs with gaps in load_vld, and random fetch bursts.
    for (int it = 0; it < 6; it++) begin
      pq.delete();
      n = $urandom_range(1, 26);
      for (int k = 0; k < n; k++) pq.push_back(16'($urandom));
      run_load(n - 1, 1'b1, it[0], -1, (it == 3) ? 1 : -1);
      fq.delete();
      for (int k = 0; k < 8; k++) fq.push_back(5'($urandom_range(0, 31)));
      fetch_seq();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
